// File: rtl/uart_nibble_rx.sv
// rtl/uart_nibble_rx.sv - UART-style 4-bit word receiver with false-start and stop-bit checks
module uart_nibble_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [3:0] out_data,
    output logic       out_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       bit_idx, bit_idx_n;
    logic [3:0]       shreg, shreg_n;
    logic [3:0]       out_data_n;
    logic             out_valid_n;
    logic             frame_err_n;
    logic             rx_meta, rx_s, rx_d;

    // Two-flop synchroniser plus one delay flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_ONE;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        out_data_n  = out_data;
        out_valid_n = 1'b0;
        frame_err_n = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                // Edge-triggered so a line parked low never restarts a frame
                if (!rx_s && rx_d) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shreg_n   = {rx_s, shreg[3:1]};
                    cnt_n     = '0;
                    bit_idx_n = bit_idx + 2'd1;
                    if (bit_idx == 2'd3) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        out_data_n  = shreg;
                        out_valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_nibble_rx.sv
// tb/tb_uart_nibble_rx.sv - self-checking bench for uart_nibble_rx
module tb_uart_nibble_rx;
    localparam int C = 16;
    localparam int H = C / 2;
    // Edge index of the stop-bit sample relative to the cycle the start bit is driven
    localparam int LAT = 1 + 2 + H + 5 * C;

    typedef struct {
        int         cyc;
        logic [3:0] data;
        logic       err;
    } pulse_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_in = 1'b1;
    logic [3:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       busy;

    int     cyc = 0;
    int     errors = 0;
    int     checks = 0;
    int     both_seen = 0;
    pulse_t got_q[$];
    pulse_t exp_q[$];
    logic   [3:0] model_data = 4'd0;

    uart_nibble_rx #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_in    (rx_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pulse_t p;
        if (out_valid === 1'b1 && frame_err === 1'b1) both_seen++;
        if (out_valid === 1'b1 || frame_err === 1'b1) begin
            p.cyc  = cyc;
            p.data = out_data;
            p.err  = (frame_err === 1'b1);
            got_q.push_back(p);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: each frame yields one pulse LAT edges after it starts
    task automatic expect_frame(input int start, input logic [3:0] w, input logic stop);
        pulse_t p;
        p.cyc  = start + LAT;
        p.data = stop ? w : model_data;
        p.err  = ~stop;
        if (stop) model_data = w;
        exp_q.push_back(p);
    endtask

    // Drives one frame bit-serially from the current post-edge point; optional reset pulse
    task automatic send_frame(input logic [3:0] w, input logic stop, input int rst_at,
                              output int start, output logic busy_after, output logic [3:0] data_after);
        logic [5:0] bits;
        int idx;
        bits       = {stop, w, 1'b0};
        start      = cyc;
        idx        = 0;
        busy_after = 1'bx;
        data_after = 4'hx;
        for (int b = 0; b < 6; b++) begin
            for (int j = 0; j < C; j++) begin
                rx_in = bits[b];
                reset = (idx == rst_at) ? 1'b0 : 1'b1;
                tick(1);
                idx++;
                if (idx == rst_at + 1) begin
                    busy_after = busy;
                    data_after = out_data;
                end
            end
        end
        reset = 1'b1;
    endtask

    task automatic verify(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cyc%0d", tag, i), got_q[i].cyc, exp_q[i].cyc);
            check($sformatf("%s_err%0d", tag, i), {31'd0, got_q[i].err}, {31'd0, exp_q[i].err});
            if (!exp_q[i].err)
                check($sformatf("%s_data%0d", tag, i), {28'd0, got_q[i].data}, {28'd0, exp_q[i].data});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int s0, s1, s2, bad, gap;
        logic ba;
        logic [3:0] da, w;
        logic st, saw_busy;

        // Reset
        reset = 1'b0;
        rx_in = 1'b1;
        tick(4);
        check("rst_out_data", {28'd0, out_data}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (out_data !== 4'd0 || out_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rst_hold", bad, 0);
        got_q.delete();

        // Single frame
        send_frame(4'd5, 1'b1, -1, s0, ba, da);
        expect_frame(s0, 4'd5, 1'b1);
        tick(20);
        verify("single");

        // Back-to-back frames, exactly 6*C apart
        send_frame(4'd5, 1'b1, -1, s0, ba, da);
        expect_frame(s0, 4'd5, 1'b1);
        send_frame(4'd4, 1'b1, -1, s1, ba, da);
        expect_frame(s1, 4'd4, 1'b1);
        send_frame(4'd6, 1'b1, -1, s2, ba, da);
        expect_frame(s2, 4'd6, 1'b1);
        check("b2b_spacing", s2 - s0, 2 * 6 * C);
        check("b2b_busy_end", {31'd0, busy}, 32'd0);
        tick(20);
        verify("b2b");

        // Glitch rejection
        saw_busy = 1'b0;
        rx_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        rx_in = 1'b1;
        bad = 1;
        for (int i = 0; i < 20 && bad != 0; i++) begin
            tick(1);
            if (busy === 1'b1) saw_busy = 1'b1;
            else if (saw_busy) bad = 0;
        end
        check("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
        check("glitch_busy_timeout", bad, 0);
        tick(2 * C);
        verify("glitch");
        check("glitch_data_kept", {28'd0, out_data}, {28'd0, model_data});

        // Framing error then recovery
        send_frame(4'd3, 1'b1, -1, s0, ba, da);
        expect_frame(s0, 4'd3, 1'b1);
        send_frame(4'hA, 1'b0, -1, s1, ba, da);
        expect_frame(s1, 4'hA, 1'b0);
        tick(C);
        rx_in = 1'b1;
        tick(C);
        check("ferr_data_kept", {28'd0, out_data}, 32'd3);
        send_frame(4'h9, 1'b1, -1, s2, ba, da);
        expect_frame(s2, 4'h9, 1'b1);
        tick(20);
        verify("ferr");
        check("ferr_recover_data", {28'd0, out_data}, 32'd9);

        // Reset during data bit 2
        send_frame(4'hC, 1'b1, 3 * C + H, s0, ba, da);
        model_data = 4'd0;
        check("midrst_busy", {31'd0, ba}, 32'd0);
        check("midrst_data", {28'd0, da}, 32'd0);
        tick(20);
        verify("midrst");
        send_frame(4'hF, 1'b1, -1, s1, ba, da);
        expect_frame(s1, 4'hF, 1'b1);
        tick(20);
        verify("after_rst");
        check("after_rst_data", {28'd0, out_data}, 32'd15);

        // Random frames with random idle gaps and occasional bad stop bits
        for (int i = 0; i < 12; i++) begin
            w  = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 4) != 0);
            send_frame(w, st, -1, s0, ba, da);
            expect_frame(s0, w, st);
            rx_in = 1'b1;
            gap = st ? $urandom_range(0, 12) : $urandom_range(H, 2 * C);
            tick(gap);
        end
        tick(C);
        verify("rand");
        check("rand_final_data", {28'd0, out_data}, {28'd0, model_data});
        check("never_both", both_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, observed=running expected=done");
        $fatal(1, "timeout");
    end

endmodule
